// File: rtl/led_pkg.sv
// Shared definitions for the LED frame buffer: FSM states, control register bits,
// default register pointers and the channel-count helper.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CTRL,
        ST_BRIGHT,
        ST_DISCARD
    } state_t;

    localparam int unsigned CTRL_LATCH_BIT   = 0;
    localparam int unsigned CTRL_BLANK_BIT   = 1;
    localparam int unsigned CTRL_OVF_CLR_BIT = 7;

    localparam logic [7:0] DEF_CTRL_ADDR   = 8'hFF;
    localparam logic [7:0] DEF_BRIGHT_ADDR = 8'hFE;

    function automatic int unsigned nch(input int unsigned led_cnt, input int unsigned ch_per_led);
        return led_cnt * ch_per_led;
    endfunction

endpackage

// File: rtl/led_scale.sv
// One output channel: registered brightness scaling (value * (bright + 1)) >> 8 with blanking,
// plus a registered flag that the output value changed on the last edge.
module led_scale (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] chan,
    input  logic [7:0] bright,
    input  logic       blank,
    output logic [7:0] scaled,
    output logic       changed
);

    logic [15:0] prod;
    logic [7:0]  scaled_d;

    // bright + 1 keeps 8'hFF an exact identity; the product never exceeds 16 bits
    always_comb begin
        prod     = 16'(chan) * (16'(bright) + 16'd1);
        scaled_d = blank ? '0 : 8'(prod >> 8);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scaled  <= '0;
            changed <= 1'b0;
        end else begin
            scaled  <= scaled_d;
            changed <= (scaled_d != scaled);
        end
    end

endmodule

// File: rtl/led_frame_buffer.sv
// I2C-fed LED register file: shadow/active channel buffers with auto-increment pointer,
// control and brightness registers, and a scaled, bit-reversed frame for the serializer.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int unsigned LED_CNT     = 3,
    parameter int unsigned CH_PER_LED  = 3,
    parameter bit          AUTO_WRAP   = 1'b1,
    parameter logic [7:0]  CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter logic [7:0]  BRIGHT_ADDR = DEF_BRIGHT_ADDR
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [7:0]                             i2c_data_i,
    input  logic [7:0]                             i2c_addr_i,
    input  logic                                   i2c_valid_i,
    input  logic                                   i2c_start_i,
    input  logic                                   i2c_stop_i,
    output logic [nch(LED_CNT, CH_PER_LED)*8-1:0]  frame_o,
    output logic                                   frame_update_o,
    output logic                                   busy_o,
    output logic                                   overflow_o
);

    localparam int unsigned NCH      = nch(LED_CNT, CH_PER_LED);
    localparam logic [8:0]  NCH_W    = 9'(NCH);
    localparam logic [7:0]  PTR_LAST = 8'(NCH - 1);

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [1:0] ctrl_q;
    logic [7:0] bright_q;
    logic       txn_wrote_q, txn_wrote_d;
    logic [7:0] shadow_q [NCH];
    logic [7:0] active_q [NCH];

    logic wr_en, ctrl_we, bright_we, ovf_set, latch_req;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        txn_wrote_d = txn_wrote_q;
        wr_en       = 1'b0;
        ctrl_we     = 1'b0;
        bright_we   = 1'b0;
        ovf_set     = 1'b0;
        latch_req   = 1'b0;

        if (i2c_start_i) begin
            ptr_d       = i2c_addr_i;
            txn_wrote_d = 1'b0;
            if (i2c_addr_i == CTRL_ADDR) begin
                state_d = ST_CTRL;
            end else if (i2c_addr_i == BRIGHT_ADDR) begin
                state_d = ST_BRIGHT;
            end else if ({1'b0, i2c_addr_i} < NCH_W) begin
                state_d = ST_WRITE;
            end else begin
                state_d = ST_DISCARD;
                ovf_set = 1'b1;
            end
        end else if (state_q != ST_IDLE) begin
            if (i2c_valid_i) begin
                case (state_q)
                    ST_WRITE: begin
                        wr_en       = 1'b1;
                        txn_wrote_d = 1'b1;
                        if (ptr_q == PTR_LAST) begin
                            if (AUTO_WRAP) begin
                                ptr_d = '0;
                            end else begin
                                state_d = ST_DISCARD;
                            end
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                    ST_CTRL:    ctrl_we   = 1'b1;
                    ST_BRIGHT:  bright_we = 1'b1;
                    ST_DISCARD: ovf_set   = 1'b1;
                    default: ;
                endcase
            end
            if (i2c_stop_i) begin
                state_d   = ST_IDLE;
                latch_req = ctrl_q[CTRL_LATCH_BIT] && (txn_wrote_q || wr_en);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            ctrl_q      <= '0;
            bright_q    <= '1;
            txn_wrote_q <= 1'b0;
            overflow_o  <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            txn_wrote_q <= txn_wrote_d;
            if (ctrl_we) begin
                ctrl_q <= i2c_data_i[1:0];
            end
            if (bright_we) begin
                bright_q <= i2c_data_i;
            end
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (ctrl_we && i2c_data_i[CTRL_OVF_CLR_BIT]) begin
                overflow_o <= 1'b0;
            end
            // The latch copy merges a byte arriving with the stop, so it lands in the same frame
            for (int unsigned k = 0; k < NCH; k++) begin
                if (wr_en && ptr_q == 8'(k)) begin
                    shadow_q[k] <= i2c_data_i;
                end
                if (latch_req) begin
                    active_q[k] <= (wr_en && ptr_q == 8'(k)) ? i2c_data_i : shadow_q[k];
                end else if (wr_en && ptr_q == 8'(k) && !ctrl_q[CTRL_LATCH_BIT]) begin
                    active_q[k] <= i2c_data_i;
                end
            end
        end
    end

    logic [NCH-1:0] chg;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [7:0] scaled;

        led_scale u_scale (
            .clk     (clk),
            .reset   (reset),
            .chan    (active_q[k]),
            .bright  (bright_q),
            .blank   (ctrl_q[CTRL_BLANK_BIT]),
            .scaled  (scaled),
            .changed (chg[k])
        );

        for (genvar i = 0; i < 8; i++) begin : g_bit
            assign frame_o[8*k+i] = scaled[7-i];
        end
    end

    assign frame_update_o = |chg;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_frame_buffer.sv
// Bench for led_frame_buffer: wrapping and non-wrapping instances on shared stimulus,
// directed sequences, a brightness table and random transactions against a behavioural model.
module tb_led_frame_buffer;

    localparam int NCH = 9;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i2c_data, i2c_addr;
    logic        i2c_valid, i2c_start, i2c_stop;
    logic [71:0] frame_w, frame_nw;
    logic        upd_w, upd_nw, busy_w, busy_nw, ovf_w, ovf_nw;

    int vectors;
    int miscompares;
    bit chk_en;

    led_frame_buffer #(.LED_CNT(3), .CH_PER_LED(3), .AUTO_WRAP(1'b1),
                       .CTRL_ADDR(8'hFF), .BRIGHT_ADDR(8'hFE)) dut (
        .clk(clk), .reset(rst_n), .i2c_data_i(i2c_data), .i2c_addr_i(i2c_addr),
        .i2c_valid_i(i2c_valid), .i2c_start_i(i2c_start), .i2c_stop_i(i2c_stop),
        .frame_o(frame_w), .frame_update_o(upd_w), .busy_o(busy_w), .overflow_o(ovf_w)
    );

    led_frame_buffer #(.LED_CNT(3), .CH_PER_LED(3), .AUTO_WRAP(1'b0),
                       .CTRL_ADDR(8'hFF), .BRIGHT_ADDR(8'hFE)) dut_nw (
        .clk(clk), .reset(rst_n), .i2c_data_i(i2c_data), .i2c_addr_i(i2c_addr),
        .i2c_valid_i(i2c_valid), .i2c_start_i(i2c_start), .i2c_stop_i(i2c_stop),
        .frame_o(frame_nw), .frame_update_o(upd_nw), .busy_o(busy_nw), .overflow_o(ovf_nw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model (index 0: wrapping, 1: non-wrapping) ----------------
    localparam int S_IDLE = 0, S_WR = 1, S_CT = 2, S_BR = 3, S_DS = 4;

    logic [7:0] m_sh  [2][NCH];
    logic [7:0] m_act [2][NCH];
    logic [7:0] e_ch  [2][NCH];
    logic [7:0] m_bri [2];
    bit         m_latch [2], m_blank [2], m_ovf [2], m_wrote [2], e_upd [2];
    int         m_st [2], m_ptr [2];

    task automatic model_step(input int w);
        logic [7:0] nf [NCH];
        bit chg;
        chg = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            nf[k] = m_blank[w] ? 8'h00 : 8'((int'(m_act[w][k]) * (int'(m_bri[w]) + 1)) / 256);
            if (nf[k] !== e_ch[w][k]) chg = 1'b1;
        end
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                m_sh[w][k] = 8'h00; m_act[w][k] = 8'h00; e_ch[w][k] = 8'h00;
            end
            e_upd[w] = 1'b0; m_bri[w] = 8'hFF; m_latch[w] = 1'b0; m_blank[w] = 1'b0;
            m_ovf[w] = 1'b0; m_wrote[w] = 1'b0; m_st[w] = S_IDLE; m_ptr[w] = 0;
            return;
        end
        for (int k = 0; k < NCH; k++) e_ch[w][k] = nf[k];
        e_upd[w] = chg;
        if (i2c_start) begin
            m_ptr[w] = int'(i2c_addr);
            m_wrote[w] = 1'b0;
            if (i2c_addr == 8'hFF) m_st[w] = S_CT;
            else if (i2c_addr == 8'hFE) m_st[w] = S_BR;
            else if (int'(i2c_addr) < NCH) m_st[w] = S_WR;
            else begin m_st[w] = S_DS; m_ovf[w] = 1'b1; end
        end else if (m_st[w] != S_IDLE) begin
            if (i2c_valid) begin
                case (m_st[w])
                    S_WR: begin
                        m_sh[w][m_ptr[w]] = i2c_data;
                        if (!m_latch[w]) m_act[w][m_ptr[w]] = i2c_data;
                        m_wrote[w] = 1'b1;
                        if (m_ptr[w] == NCH - 1) begin
                            if (w == 0) m_ptr[w] = 0; else m_st[w] = S_DS;
                        end else m_ptr[w]++;
                    end
                    S_CT: begin
                        m_latch[w] = i2c_data[0];
                        m_blank[w] = i2c_data[1];
                        if (i2c_data[7]) m_ovf[w] = 1'b0;
                    end
                    S_BR: m_bri[w] = i2c_data;
                    S_DS: m_ovf[w] = 1'b1;
                    default: ;
                endcase
            end
            if (i2c_stop) begin
                if (m_latch[w] && m_wrote[w])
                    for (int k = 0; k < NCH; k++) m_act[w][k] = m_sh[w][k];
                m_st[w] = S_IDLE;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [71:0] pack(input int w);
        logic [71:0] r;
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < 8; i++) r[8*k+i] = e_ch[w][k][7-i];
        return r;
    endfunction

    function automatic logic [7:0] chan(input logic [71:0] f, input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = f[8*k+i];
        return r;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chkf(input string nm, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chkf("mon_frame_wrap", frame_w, pack(0));
            chkf("mon_frame_nowrap", frame_nw, pack(1));
            chk1("mon_update_wrap", upd_w, e_upd[0]);
            chk1("mon_update_nowrap", upd_nw, e_upd[1]);
            chk1("mon_busy_wrap", busy_w, m_st[0] != S_IDLE);
            chk1("mon_busy_nowrap", busy_nw, m_st[1] != S_IDLE);
            chk1("mon_ovf_wrap", ovf_w, m_ovf[0]);
            chk1("mon_ovf_nowrap", ovf_nw, m_ovf[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit s, input logic [7:0] a, input bit v, input logic [7:0] d, input bit p);
        @(negedge clk);
        i2c_start = s; i2c_addr = a; i2c_valid = v; i2c_data = d; i2c_stop = p;
    endtask

    task automatic nop(input int n);
        repeat (n) drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic txn(input logic [7:0] a, input int n, input logic [7:0] b0,
                       input logic [7:0] b1 = 8'h00, input logic [7:0] b2 = 8'h00);
        logic [7:0] b [3];
        b[0] = b0; b[1] = b1; b[2] = b2;
        drv(1'b1, a, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) drv(1'b0, 8'h00, 1'b1, b[i], 1'b0);
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        nop(3);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        i2c_start = 1'b0; i2c_valid = 1'b0; i2c_stop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] bright;
        logic [7:0] val;
        logic [7:0] ctrl;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        vectors = 0; miscompares = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        i2c_start = 1'b0; i2c_valid = 1'b0; i2c_stop = 1'b0; i2c_addr = 8'h00; i2c_data = 8'h00;

        tbl[0] = '{8'hFF, 8'h12, 8'h00, 8'h12};
        tbl[1] = '{8'h7F, 8'hFF, 8'h00, 8'h7F};
        tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'h00};
        tbl[3] = '{8'h80, 8'h80, 8'h00, 8'h40};
        tbl[4] = '{8'h01, 8'hFF, 8'h00, 8'h01};
        tbl[5] = '{8'h40, 8'hC8, 8'h00, 8'h32};
        tbl[6] = '{8'hFF, 8'hFF, 8'h02, 8'h00};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chkf("reset_frame", frame_w, 72'h0);
        chk1("reset_busy", busy_w, 1'b0);
        chk1("reset_ovf", ovf_nw, 1'b0);
        chk1("reset_update", upd_w, 1'b0);

        // Immediate write: bit reversal and two-cycle update latency
        drv(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk1("imm_busy", busy_w, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h12, 1'b0);
        chk1("imm_busy_active", busy_w, 1'b1);
        nop(1);
        chk1("imm_upd_early", upd_w, 1'b0);
        chk8("imm_frame_early", frame_w[7:0], 8'h00);
        nop(1);
        chk1("imm_upd_pulse", upd_w, 1'b1);
        chk8("imm_bitrev", frame_w[7:0], 8'h48);
        nop(1);
        chk1("imm_upd_single", upd_w, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h34, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h56, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        nop(3);
        chk8("imm_ch1", chan(frame_w, 1), 8'h34);
        chk8("imm_ch2", chan(frame_w, 2), 8'h56);
        chk1("imm_idle", busy_w, 1'b0);

        // Pointer wrap vs discard past the last channel
        txn(8'h08, 2, 8'hAA, 8'hBB);
        chk8("wrap_ch8", chan(frame_w, 8), 8'hAA);
        chk8("wrap_ch0", chan(frame_w, 0), 8'hBB);
        chk1("wrap_no_ovf", ovf_w, 1'b0);
        chk8("nowrap_ch8", chan(frame_nw, 8), 8'hAA);
        chk8("nowrap_ch0_kept", chan(frame_nw, 0), 8'h12);
        chk1("nowrap_ovf", ovf_nw, 1'b1);
        txn(8'hFF, 1, 8'h80);
        chk1("ovf_cleared", ovf_nw, 1'b0);

        // Latched mode: frame holds until stop, then updates two cycles later
        txn(8'hFF, 1, 8'h01);
        drv(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h7F, 1'b0);
        nop(3);
        chk8("latch_hold", chan(frame_w, 1), 8'h34);
        chk1("latch_no_upd", upd_w, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        nop(1);
        chk8("latch_hold_stop", chan(frame_w, 1), 8'h34);
        nop(1);
        chk8("latch_applied", chan(frame_w, 1), 8'h7F);
        chk1("latch_upd_pulse", upd_w, 1'b1);
        txn(8'hFF, 1, 8'h00);

        // Brightness / blank table
        for (int i = 0; i < 7; i++) begin
            txn(8'hFE, 1, tbl[i].bright);
            txn(8'hFF, 1, tbl[i].ctrl);
            txn(8'h00, 1, tbl[i].val);
            chk8($sformatf("bright_tbl%0d", i), chan(frame_w, 0), tbl[i].exp);
            if (tbl[i].ctrl[1]) chkf("blank_all", frame_w, 72'h0);
        end
        txn(8'hFF, 1, 8'h00);
        txn(8'hFE, 1, 8'hFF);

        // Repeated start redirects the pointer
        drv(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
        drv(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h44, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        nop(3);
        chk8("rs_ch0", chan(frame_w, 0), 8'h11);
        chk8("rs_ch4", chan(frame_w, 4), 8'h44);
        chk8("rs_ch1_kept", chan(frame_w, 1), 8'h7F);

        // Reset in the middle of a transaction
        drv(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
        nop(1);
        chk1("mid_busy", busy_w, 1'b1);
        rst_pulse();
        chkf("mid_rst_frame", frame_w, 72'h0);
        chk1("mid_rst_busy", busy_w, 1'b0);
        txn(8'h00, 1, 8'h12);
        chk8("post_rst_identity", chan(frame_w, 0), 8'h12);
        chk8("post_rst_ch2", chan(frame_w, 2), 8'h00);

        // Random transactions checked by the model
        for (int t = 0; t < 300; t++) begin
            int r, nb;
            logic [7:0] a, d;
            bit stopped;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                rst_pulse();
                continue;
            end
            case ($urandom_range(0, 7))
                6: a = 8'hFE;
                7: a = 8'hFF;
                default: a = 8'($urandom_range(0, 11));
            endcase
            nb = int'($urandom_range(0, 4));
            stopped = 1'b0;
            drv(1'b1, a, 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 2) == 0) nop(1);
                if ($urandom_range(0, 9) == 0)
                    drv(1'b1, 8'($urandom_range(0, 9)), 1'b0, 8'h00, 1'b0);
                d = 8'($urandom);
                if (a == 8'hFF) d[1] = ($urandom_range(0, 3) == 0);
                if (i == nb - 1 && $urandom_range(0, 2) == 0) begin
                    drv(1'b0, 8'h00, 1'b1, d, 1'b1);
                    stopped = 1'b1;
                end else begin
                    drv(1'b0, 8'h00, 1'b1, d, 1'b0);
                end
            end
            if (!stopped) drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            nop(int'($urandom_range(0, 3)));
        end
        nop(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
